load_store_unit: RTL and testbench

Sits between the core's execute stage and the byte-enabled data memory, and turns RISC-V load/store requests (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-aligned memory accesses. It uses a request handshake and drives memory word address, byte enables, lane-shifted write data and write enable. Loads are merged, shifted and sign/zero-extended. Any access that crosses a word boundary is split into two consecutive aligned accesses, so memory never receives a misaligned address.

---
 rtl/load_store_unit.sv | 177 +++++++++++++++++
 tb/tb_load_store_unit.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Turns RISC-V byte/half/word loads and stores into word-aligned
//               byte-enabled memory accesses, splitting boundary-crossing ones.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_en,
    output logic        mem_w_en,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_lo;
    logic        r_we;
    logic [2:0]  r_funct3;

    logic        w_req_legal;
    logic [3:0]  w_req_en;
    logic [31:0] w_req_wd;
    logic [3:0]  w_hi_en;
    logic [31:0] w_hi_wd;
    logic        w_split;

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_bits(input logic [3:0] en);
        return {{8{en[3]}}, {8{en[2]}}, {8{en[1]}}, {8{en[0]}}};
    endfunction

    function automatic logic legal_op(input logic [2:0] f3, input logic we);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return ~we;
            default:                return 1'b0;
        endcase
    endfunction

    // Shift the {hi,lo} word pair down to the access offset, then extend.
    function automatic logic [31:0] extract(input logic [63:0] pair,
                                            input logic [1:0]  off,
                                            input logic [2:0]  f3);
        logic [31:0] s;
        s = 32'(pair >> {off, 3'b000});
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b100:  return {24'd0, s[7:0]};
            3'b101:  return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    assign w_req_legal = legal_op(req_funct3, req_we);
    assign w_req_en    = size_mask(req_funct3[1:0]) << req_addr[1:0];
    assign w_req_wd    = req_wdata << {req_addr[1:0], 3'b000};

    // Bytes that spill past lane 3 land in the low lanes of the next word.
    assign w_hi_en = size_mask(r_funct3[1:0]) >> (3'd4 - {1'b0, r_addr[1:0]});
    assign w_hi_wd = (r_wdata >> {(3'd4 - {1'b0, r_addr[1:0]}), 3'b000}) & lane_bits(w_hi_en);
    assign w_split = |w_hi_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_addr         <= 32'd0;
            r_wdata        <= 32'd0;
            r_lo           <= 32'd0;
            r_we           <= 1'b0;
            r_funct3       <= 3'd0;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_err        <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            mem_byte_en    <= 4'd0;
            mem_w_en       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        req_ready <= 1'b0;
                        if (w_req_legal) begin
                            r_state        <= S_ACC0;
                            mem_address    <= {req_addr[31:2], 2'b00};
                            mem_byte_en    <= w_req_en;
                            mem_write_data <= w_req_wd & lane_bits(w_req_en);
                            mem_w_en       <= req_we;
                        end else begin
                            r_state   <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end
                    end
                end
                S_ACC0: begin
                    if (!r_we) begin
                        r_lo <= mem_read_data;
                    end
                    if (w_split) begin
                        r_state        <= S_ACC1;
                        mem_address    <= {r_addr[31:2], 2'b00} + 32'd4;
                        mem_byte_en    <= w_hi_en;
                        mem_write_data <= w_hi_wd;
                        mem_w_en       <= r_we;
                    end else begin
                        r_state        <= S_DONE;
                        mem_address    <= 32'd0;
                        mem_byte_en    <= 4'd0;
                        mem_write_data <= 32'd0;
                        mem_w_en       <= 1'b0;
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= r_we ? 32'd0
                                               : extract({32'd0, mem_read_data}, r_addr[1:0], r_funct3);
                    end
                end
                S_ACC1: begin
                    r_state        <= S_DONE;
                    mem_address    <= 32'd0;
                    mem_byte_en    <= 4'd0;
                    mem_write_data <= 32'd0;
                    mem_w_en       <= 1'b0;
                    rsp_valid      <= 1'b1;
                    rsp_rdata      <= r_we ? 32'd0
                                           : extract({mem_read_data, r_lo}, r_addr[1:0], r_funct3);
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_en;
    logic        mem_w_en;
    logic [31:0] mem_read_data;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem_bytes [256];
    logic [7:0] shadow    [256];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } acc_t;
    acc_t acc_q[$];

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_byte_en(mem_byte_en), .mem_w_en(mem_w_en), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // 256-byte memory, aliased on address bits [7:0]
    always @(posedge clk) begin
        if (mem_w_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_en[i]) mem_bytes[mem_address[7:0] + 8'(i)] <= mem_write_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        mem_read_data = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mem_read_data[8*i +: 8] = mem_bytes[{mem_address[7:2], 2'b00} + 8'(i)];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            tests_run++;
            if (mem_address[1:0] !== 2'b00 || (!rsp_valid && (rsp_rdata !== 32'd0 || rsp_err !== 1'b0))) begin
                tests_failed++;
                $display("FAIL monitor: addr=%h rsp_valid=%b rdata=%h err=%b required aligned addr and idle rsp zero",
                         mem_address, rsp_valid, rsp_rdata, rsp_err);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic is_legal(input logic [2:0] f3, input logic we);
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) return 1'b1;
        if (f3 == 3'b100 || f3 == 3'b101) return !we;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < size_of(f3); i++) v[8*i +: 8] = shadow[8'(a + 32'(i))];
        if (f3 == 3'b000 && v[7])  v |= 32'hFFFF_FF00;
        if (f3 == 3'b001 && v[15]) v |= 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        for (int i = 0; i < size_of(f3); i++) shadow[8'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    function automatic logic mem_matches();
        for (int i = 0; i < 256; i++) if (mem_bytes[i] !== shadow[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- driver ----------------
    task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                           input logic [2:0] f3, output logic [31:0] rd, output logic err,
                           output int lat, output logic ready_ok);
        acc_t r;
        @(negedge clk);
        req_addr = a; req_wdata = wd; req_we = we; req_funct3 = f3; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc_q.delete();
        lat = 0;
        ready_ok = 1'b1;
        while (!rsp_valid && lat < 8) begin
            if (req_ready) ready_ok = 1'b0;
            if (mem_byte_en != 4'd0 || mem_w_en) begin
                r.addr = mem_address; r.be = mem_byte_en; r.wd = mem_write_data; r.we = mem_w_en;
                acc_q.push_back(r);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (req_ready) ready_ok = 1'b0;
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        #1;
        if (!req_ready || rsp_valid) ready_ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_byte_en, mem_w_en}
            !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b addr=%h wd=%h be=%b we=%b required ready=1, rest 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_byte_en, mem_w_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        logic [31:0] rd, wd;
        logic err, rok;
        int lat;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            run_req(32'(w * 4), wd, 1'b1, 3'b010, rd, err, lat, rok);
            ref_store(32'(w * 4), wd, 3'b010);
        end
        tests_run++;
        if (!mem_matches()) begin
            tests_failed++;
            $display("FAIL preload_mem: memory contents differ from model, required equal");
        end
    endtask

    task automatic test_store_word();
        logic [31:0] rd;
        logic err, rok;
        int lat;
        run_req(32'h10, 32'hDEADBEEF, 1'b1, 3'b010, rd, err, lat, rok);
        ref_store(32'h10, 32'hDEADBEEF, 3'b010);
        tests_run++;
        if (acc_q.size() != 1 || {acc_q[0].addr, acc_q[0].be, acc_q[0].wd, acc_q[0].we}
            !== {32'h10, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
            tests_failed++;
            $display("FAIL sw_access: n=%0d got %h/%b/%h/%b required 00000010/1111/deadbeef/1",
                     acc_q.size(), acc_q.size() ? acc_q[0].addr : 32'd0, acc_q.size() ? acc_q[0].be : 4'd0,
                     acc_q.size() ? acc_q[0].wd : 32'd0, acc_q.size() ? acc_q[0].we : 1'b0);
        end
        tests_run++;
        if ({lat, err, rd, rok} !== {32'd1, 1'b0, 32'd0, 1'b1}) begin
            tests_failed++;
            $display("FAIL sw_resp: lat=%0d err=%b rdata=%h ready_ok=%b required 1/0/0/1", lat, err, rd, rok);
        end
        tests_run++;
        if (!mem_matches()) begin
            tests_failed++;
            $display("FAIL sw_mem: memory differs from model, required equal");
        end
    endtask

    task automatic test_load_ext();
        logic [31:0] rd;
        logic err, rok;
        int lat;
        logic [31:0] addrs [4];
        logic [2:0]  f3s   [4];
        logic [31:0] exps  [4];
        addrs = '{32'h13, 32'h13, 32'h12, 32'h12};
        f3s   = '{3'b000, 3'b100, 3'b101, 3'b001};
        exps  = '{32'hFFFFFF80, 32'h00000080, 32'h00008000, 32'hFFFF8000};
        run_req(32'h10, 32'h80000000, 1'b1, 3'b010, rd, err, lat, rok);
        ref_store(32'h10, 32'h80000000, 3'b010);
        for (int i = 0; i < 4; i++) begin
            run_req(addrs[i], 32'hFFFFFFFF, 1'b0, f3s[i], rd, err, lat, rok);
            tests_run++;
            if ({rd, err, lat, rok} !== {exps[i], 1'b0, 32'd1, 1'b1} || acc_q.size() != 1 ||
                acc_q[0].we !== 1'b0) begin
                tests_failed++;
                $display("FAIL load_ext[%0d]: rdata=%h err=%b lat=%0d ready_ok=%b required %h/0/1/1",
                         i, rd, err, lat, rok, exps[i]);
            end
        end
    endtask

    task automatic test_split_store();
        logic [31:0] rd;
        logic err, rok;
        int lat;
        run_req(32'h23, 32'h0000ABCD, 1'b1, 3'b001, rd, err, lat, rok);
        ref_store(32'h23, 32'h0000ABCD, 3'b001);
        tests_run++;
        if (acc_q.size() != 2 ||
            {acc_q[0].addr, acc_q[0].be, acc_q[0].wd, acc_q[0].we} !== {32'h20, 4'b1000, 32'hCD000000, 1'b1} ||
            {acc_q[1].addr, acc_q[1].be, acc_q[1].wd, acc_q[1].we} !== {32'h24, 4'b0001, 32'h000000AB, 1'b1}) begin
            tests_failed++;
            $display("FAIL split_store_access: %0d accesses seen, required 00000020/1000/cd000000 then 00000024/0001/000000ab",
                     acc_q.size());
        end
        tests_run++;
        if ({lat, err, rok} !== {32'd2, 1'b0, 1'b1} || !mem_matches()) begin
            tests_failed++;
            $display("FAIL split_store_resp: lat=%0d err=%b ready_ok=%b required 2/0/1 and memory equal", lat, err, rok);
        end
    endtask

    task automatic test_split_load();
        logic [31:0] rd;
        logic err, rok;
        int lat;
        run_req(32'h04, 32'h44332211, 1'b1, 3'b010, rd, err, lat, rok);
        run_req(32'h08, 32'h88776655, 1'b1, 3'b010, rd, err, lat, rok);
        run_req(32'h05, 32'h0, 1'b0, 3'b010, rd, err, lat, rok);
        tests_run++;
        if ({rd, err, lat} !== {32'h55443322, 1'b0, 32'd2}) begin
            tests_failed++;
            $display("FAIL split_lw: rdata=%h err=%b lat=%0d required 55443322/0/2", rd, err, lat);
        end
        run_req(32'hFFFFFFFC, 32'h7F000000, 1'b1, 3'b010, rd, err, lat, rok);
        run_req(32'h00000000, 32'h000000C3, 1'b1, 3'b010, rd, err, lat, rok);
        ref_store(32'h04, 32'h44332211, 3'b010);
        ref_store(32'h08, 32'h88776655, 3'b010);
        ref_store(32'hFFFFFFFC, 32'h7F000000, 3'b010);
        ref_store(32'h0, 32'h000000C3, 3'b010);
        run_req(32'hFFFFFFFF, 32'h0, 1'b0, 3'b001, rd, err, lat, rok);
        tests_run++;
        if (acc_q.size() != 2 || acc_q[0].addr !== 32'hFFFFFFFC || acc_q[1].addr !== 32'h0 ||
            acc_q[0].be !== 4'b1000 || acc_q[1].be !== 4'b0001 || {rd, lat} !== {32'hFFFFC37F, 32'd2}) begin
            tests_failed++;
            $display("FAIL wrap_lh: %0d accesses, rdata=%h lat=%0d required fffffffc then 00000000, ffffc37f/2",
                     acc_q.size(), rd, lat);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] rd;
        logic err, rok;
        int lat;
        logic [2:0] f3s [4];
        logic       wes [4];
        f3s = '{3'b011, 3'b100, 3'b110, 3'b101};
        wes = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_req(32'h30, 32'h12345678, wes[i], f3s[i], rd, err, lat, rok);
            tests_run++;
            if ({lat, err, rd, rok} !== {32'd0, 1'b1, 32'd0, 1'b1} || acc_q.size() != 0 || !mem_matches()) begin
                tests_failed++;
                $display("FAIL illegal[%0d]: lat=%0d err=%b rdata=%h accesses=%0d required 0/1/0/0 and memory unchanged",
                         i, lat, err, rd, acc_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic bad;
        @(negedge clk);
        req_addr = 32'h23; req_wdata = 32'h00005A5A; req_we = 1'b1; req_funct3 = 3'b001; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        // Reset is sampled on the edge that would launch the second half.
        @(negedge clk);
        rst_n = 1'b0;
        shadow[8'h23] = 8'h5A;
        @(posedge clk);
        #1;
        bad = rsp_valid | mem_w_en | (mem_byte_en != 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_ready: req_ready=%b required 1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            bad |= rsp_valid | mem_w_en;
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (bad !== 1'b0 || !mem_matches()) begin
            tests_failed++;
            $display("FAIL reset_mid_drop: activity=%b required 0, second write must not reach memory", bad);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, rd, exp_rd;
        logic [31:0] e_wd0, e_wd1;
        logic [3:0]  e_be0, e_be1;
        logic [2:0]  f3;
        logic [2:0]  tab [8];
        logic we, err, rok, lg, split;
        int lat, idx, n, o, p, e_lat;
        tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int t = 0; t < 300; t++) begin
            a   = $urandom;
            wd  = $urandom;
            we  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 9);
            f3  = (idx > 7) ? 3'b010 : tab[idx];
            lg  = is_legal(f3, we);
            n   = size_of(f3);
            o   = int'(a[1:0]);
            split = (o + n > 4);
            e_lat = !lg ? 0 : (split ? 2 : 1);
            exp_rd = (lg && !we) ? ref_load(a, f3) : 32'd0;
            e_be0 = '0; e_be1 = '0; e_wd0 = '0; e_wd1 = '0;
            for (int i = 0; i < n; i++) begin
                p = o + i;
                if (p < 4) begin
                    e_be0[p] = 1'b1; e_wd0[8*p +: 8] = wd[8*i +: 8];
                end else begin
                    e_be1[p-4] = 1'b1; e_wd1[8*(p-4) +: 8] = wd[8*i +: 8];
                end
            end
            run_req(a, wd, we, f3, rd, err, lat, rok);
            if (lg && we) ref_store(a, wd, f3);
            tests_run++;
            if ({rd, err, lat, rok} !== {exp_rd, !lg, e_lat, 1'b1}) begin
                tests_failed++;
                $display("FAIL rand_resp[%0d]: a=%h f3=%b we=%b rdata=%h err=%b lat=%0d rok=%b required %h/%b/%0d/1",
                         t, a, f3, we, rd, err, lat, rok, exp_rd, !lg, e_lat);
            end
            tests_run++;
            if (acc_q.size() != e_lat ||
                (e_lat >= 1 && ({acc_q[0].addr, acc_q[0].be, acc_q[0].we} !== {a & 32'hFFFFFFFC, e_be0, we} ||
                                (we && acc_q[0].wd !== e_wd0))) ||
                (e_lat == 2 && ({acc_q[1].addr, acc_q[1].be, acc_q[1].we} !== {(a & 32'hFFFFFFFC) + 32'd4, e_be1, we} ||
                                (we && acc_q[1].wd !== e_wd1)))) begin
                tests_failed++;
                $display("FAIL rand_access[%0d]: a=%h f3=%b we=%b accesses=%0d required %0d with be %b/%b wd %h/%h",
                         t, a, f3, we, acc_q.size(), e_lat, e_be0, e_be1, e_wd0, e_wd1);
            end
            tests_run++;
            if (!mem_matches()) begin
                tests_failed++;
                $display("FAIL rand_mem[%0d]: memory differs from model after a=%h f3=%b we=%b", t, a, f3, we);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_store_word();
        test_load_ext();
        test_split_store();
        test_split_load();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
